pattern_load_ctrl: RTL and testbench

- Sequencer that sits between the pattern selector/ROM and the Game of Life cell grid/evolution engine.
- On a load request it latches the 2-bit switch selection and streams the chosen pattern into the grid, one cell per clock.
- It then paces generation steps with a tick divider and a start/done handshake to the evolution engine, under run/pause control.

---
 rtl/pattern_load_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pattern_load_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_load_ctrl.sv
// Purpose : loads a selected Life pattern into the cell grid, then paces generation steps.
// Latency : first cell write one cycle after load_req; gen_start TICK_DIV cycles into RUN.
// Backpressure: none; WAIT_GEN stalls stepping until gen_done, and load_req is dropped there.
//
// Ports:
//   clk, reset_n        : clock, synchronous active-low reset
//   sel_in, load_req    : pattern switches and load pulse
//   run_toggle          : run/pause toggle pulse
//   pat_bit             : combinational ROM bit for (pat_sel, cell_addr)
//   gen_done            : generation-finished pulse from the evolution engine
//   pat_sel             : latched pattern select driving the ROM
//   cell_addr/_wdata/_we: row-major grid write port (wdata gated by we)
//   gen_start           : one-cycle request for a single generation
//   busy, running       : status (LOAD/WAIT_GEN, RUN/WAIT_GEN)
//   gen_count           : generations completed since the last load
//
// Build option: define PATTERN_AUTORUN_EN to start stepping automatically
// once the last cell of a pattern has been written.
module pattern_load_ctrl #(
  parameter int ROWS     = 16,
  parameter int COLS     = 16,
  parameter int TICK_DIV = 25000000
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [1:0]                      sel_in,
  input  logic                            load_req,
  input  logic                            run_toggle,
  input  logic                            pat_bit,
  input  logic                            gen_done,
  output logic [1:0]                      pat_sel,
  output logic [$clog2(ROWS*COLS)-1:0]    cell_addr,
  output logic                            cell_wdata,
  output logic                            cell_we,
  output logic                            gen_start,
  output logic                            busy,
  output logic                            running,
  output logic [15:0]                     gen_count
);

  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(ROWS * COLS);
  localparam int TW = $clog2(TICK_DIV);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_PAUSED   = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_WAIT_GEN = 3'd4;

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [1:0]    r_pat_sel;
  logic [AW-1:0] r_addr;
  logic          r_we;
  logic          r_gen_start;
  logic          r_busy;
  logic          r_running;
  logic          r_pause_pending;
  logic [15:0]   r_gen_count;
  logic [TW-1:0] r_tick;

  logic          w_last_cell;
  logic          w_tick_done;
  logic          w_start_load;

  assign w_last_cell  = (r_addr == AW'(N - 1));
  assign w_tick_done  = (r_tick == TW'(TICK_DIV - 1));
  assign w_start_load = (w_next == S_LOAD) && (r_state != S_LOAD);

  // Next-state decision. Within PAUSED/RUN a load request outranks a toggle,
  // and in RUN a toggle outranks tick expiry.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (load_req) w_next = S_LOAD;
      end
      S_LOAD: begin
        if (w_last_cell) begin
`ifdef PATTERN_AUTORUN_EN
          w_next = S_RUN;
`else
          w_next = S_PAUSED;
`endif
        end
      end
      S_PAUSED: begin
        if (load_req)        w_next = S_LOAD;
        else if (run_toggle) w_next = S_RUN;
      end
      S_RUN: begin
        if (load_req)         w_next = S_LOAD;
        else if (run_toggle)  w_next = S_PAUSED;
        else if (w_tick_done) w_next = S_WAIT_GEN;
      end
      S_WAIT_GEN: begin
        // A toggle arriving with gen_done is folded in before deciding.
        if (gen_done) w_next = (r_pause_pending ^ run_toggle) ? S_PAUSED : S_RUN;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_pat_sel       <= 2'd0;
      r_addr          <= '0;
      r_we            <= 1'b0;
      r_gen_start     <= 1'b0;
      r_busy          <= 1'b0;
      r_running       <= 1'b0;
      r_pause_pending <= 1'b0;
      r_gen_count     <= 16'd0;
      r_tick          <= '0;
    end else begin
      r_state     <= w_next;
      // Status outputs are registered from the next state so they line up
      // with the cycle the state is actually occupied.
      r_we        <= (w_next == S_LOAD);
      r_busy      <= (w_next == S_LOAD) || (w_next == S_WAIT_GEN);
      r_running   <= (w_next == S_RUN)  || (w_next == S_WAIT_GEN);
      r_gen_start <= (r_state == S_RUN) && (w_next == S_WAIT_GEN);

      if (w_start_load) begin
        r_pat_sel <= sel_in;
        r_addr    <= '0;
      end else if ((r_state == S_LOAD) && !w_last_cell) begin
        r_addr    <= r_addr + AW'(1);
      end

      if ((r_state == S_LOAD) && w_last_cell) begin
        r_gen_count <= 16'd0;
      end else if ((r_state == S_WAIT_GEN) && gen_done) begin
        r_gen_count <= r_gen_count + 16'd1;
      end

      // Tick restarts on every entry into RUN; it is held when RUN is left
      // for PAUSED and cleared when a generation is requested.
      if ((w_next == S_RUN) && (r_state != S_RUN)) begin
        r_tick <= '0;
      end else if ((r_state == S_RUN) && (w_next == S_RUN)) begin
        r_tick <= r_tick + TW'(1);
      end else if ((r_state == S_RUN) && (w_next == S_WAIT_GEN)) begin
        r_tick <= '0;
      end

      if (r_state == S_WAIT_GEN) begin
        if (gen_done)        r_pause_pending <= 1'b0;
        else if (run_toggle) r_pause_pending <= ~r_pause_pending;
      end
    end
  end

  assign pat_sel    = r_pat_sel;
  assign cell_addr  = r_addr;
  assign cell_we    = r_we;
  assign cell_wdata = r_we & pat_bit;
  assign gen_start  = r_gen_start;
  assign busy       = r_busy;
  assign running    = r_running;
  assign gen_count  = r_gen_count;

endmodule

// File: tb/tb_pattern_load_ctrl.sv
// Bench for pattern_load_ctrl with a 4x4 grid and a 4-cycle tick.
// The engine model raises gen_done in the eng_lat-th cycle of a generation,
// counting the gen_start cycle as the first, so starts are TICK_DIV+eng_lat apart.
module tb_pattern_load_ctrl;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int TICK_DIV = 4;
  localparam int NC       = ROWS * COLS;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  sel_in = 2'd0;
  logic        load_req = 1'b0;
  logic        run_toggle = 1'b0;
  logic        pat_bit;
  logic        gen_done = 1'b0;
  logic [1:0]  pat_sel;
  logic [3:0]  cell_addr;
  logic        cell_wdata;
  logic        cell_we;
  logic        gen_start;
  logic        busy;
  logic        running;
  logic [15:0] gen_count;

  logic [15:0] rom [4];
  int          n_checks = 0;
  int          n_fail = 0;
  int          eng_lat = 3;
  int          eng_cnt = 0;
  logic        stray_done = 1'b0;
  logic [15:0] exp_count = 16'd0;
  logic [1:0]  exp_sel = 2'd0;

  always #5 clk = ~clk;

  assign pat_bit = rom[pat_sel][cell_addr];

  pattern_load_ctrl #(.ROWS(ROWS), .COLS(COLS), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .sel_in(sel_in), .load_req(load_req),
    .run_toggle(run_toggle), .pat_bit(pat_bit), .gen_done(gen_done),
    .pat_sel(pat_sel), .cell_addr(cell_addr), .cell_wdata(cell_wdata),
    .cell_we(cell_we), .gen_start(gen_start), .busy(busy), .running(running),
    .gen_count(gen_count)
  );

  // Evolution engine model.
  always begin
    @(posedge clk);
    #2;
    gen_done = stray_done;
    if (gen_start === 1'b1) eng_cnt = eng_lat;
    if (eng_cnt > 0) begin
      eng_cnt = eng_cnt - 1;
      if (eng_cnt == 0) gen_done = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [26:0] got;
    logic        bad;
    reset_n = 1'b0; load_req = 1'b0; run_toggle = 1'b0; sel_in = 2'd0;
    cyc(); cyc();
    got = {pat_sel, cell_addr, cell_we, cell_wdata, gen_start, busy, running, gen_count};
    n_checks++;
    if (got !== 27'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0", got);
    end
    reset_n = 1'b1;
    cyc();
    run_toggle = 1'b1; cyc(); run_toggle = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (running !== 1'b0 || busy !== 1'b0 || gen_start !== 1'b0 || cell_we !== 1'b0) bad = 1'b1;
      cyc();
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL idle_ignores_toggle: got activity=%b required 0", bad);
    end
  endtask

  task automatic do_load(input logic [1:0] sel, input logic with_toggle, input string tag);
    logic [9:0] got;
    logic [9:0] exp;
    n_checks++;
    if (cell_we !== 1'b0) begin
      n_fail++; $display("FAIL %s_pre_we: got %b required 0", tag, cell_we);
    end
    sel_in = sel; load_req = 1'b1; run_toggle = with_toggle;
    cyc();
    load_req = 1'b0; run_toggle = 1'b0; sel_in = sel + 2'd1;
    for (int i = 0; i < NC; i++) begin
      got = {cell_we, cell_addr, cell_wdata, pat_sel, busy, running};
      exp = {1'b1, 4'(i), rom[sel][i], sel, 1'b1, 1'b0};
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL %s_write%0d: got %b required %b", tag, i, got, exp);
      end
      if (i == 7) begin
        load_req = 1'b1; run_toggle = 1'b1;
      end else begin
        load_req = 1'b0; run_toggle = 1'b0;
      end
      cyc();
    end
    load_req = 1'b0; run_toggle = 1'b0;
    exp_count = 16'd0;
    exp_sel = sel;
    n_checks++;
    if ({cell_we, cell_wdata, busy, running, gen_count} !== 20'd0) begin
      n_fail++;
      $display("FAIL %s_end: got we=%b wd=%b busy=%b run=%b cnt=%0d required all 0",
               tag, cell_we, cell_wdata, busy, running, gen_count);
    end
  endtask

  task automatic test_load();
    do_load(2'd2, 1'b0, "load_sel2");
    stray_done = 1'b1; cyc(); stray_done = 1'b0; cyc();
    n_checks++;
    if ({running, gen_count} !== {1'b0, exp_count}) begin
      n_fail++; $display("FAIL stray_done: got run=%b cnt=%0d required run=0 cnt=%0d",
                         running, gen_count, exp_count);
    end
  endtask

  // Called in the first RUN cycle with the tick at 0.
  task automatic run_steps(input int lat, input int ngen, input string tag);
    int         per;
    int         last;
    int         done_before;
    logic       exp_start;
    logic       in_wait;
    logic [18:0] got;
    logic [18:0] exp;
    per  = TICK_DIV + lat;
    last = TICK_DIV + (ngen - 1) * per + lat - 1;
    for (int c = 0; c <= last; c++) begin
      exp_start   = (c >= TICK_DIV) && (((c - TICK_DIV) % per) == 0);
      in_wait     = (c >= TICK_DIV) && (((c - TICK_DIV) % per) < lat);
      done_before = (c < TICK_DIV + lat) ? 0 : ((c - TICK_DIV - lat) / per + 1);
      got = {gen_start, busy, running, gen_count};
      exp = {exp_start, in_wait, 1'b1, exp_count + 16'(done_before)};
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL %s_c%0d: got start/busy/run/cnt=%h required %h", tag, c, got, exp);
      end
      cyc();
    end
    exp_count = exp_count + 16'(ngen);
  endtask

  task automatic pause_from_run(input string tag);
    logic bad;
    run_toggle = 1'b1; cyc(); run_toggle = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 3 * TICK_DIV; c++) begin
      if (gen_start !== 1'b0 || running !== 1'b0) bad = 1'b1;
      cyc();
    end
    n_checks++;
    if ({bad, gen_count} !== {1'b0, exp_count}) begin
      n_fail++; $display("FAIL %s_paused: got activity=%b cnt=%0d required 0 cnt=%0d",
                         tag, bad, gen_count, exp_count);
    end
  endtask

  task automatic test_stepping();
    int lat;
    int ngen;
    eng_lat = 3;
    run_toggle = 1'b1; cyc(); run_toggle = 1'b0;
    run_steps(3, 3, "step_l3");
    pause_from_run("step_l3");
    lat  = $urandom_range(1, 5);
    ngen = $urandom_range(1, 3);
    eng_lat = lat;
    run_toggle = 1'b1; cyc(); run_toggle = 1'b0;
    run_steps(lat, ngen, "step_rand");
    pause_from_run("step_rand");
  endtask

  // Starts from PAUSED, toggles inside WAIT_GEN in the cycles flagged by
  // mask (bit 0 = gen_start cycle) and ends in PAUSED.
  task automatic test_wait_toggle(input int lat, input logic [7:0] mask, input string tag);
    int   waited;
    int   ntog;
    logic bad;
    eng_lat = lat;
    run_toggle = 1'b1; cyc(); run_toggle = 1'b0;
    waited = 0;
    while (gen_start !== 1'b1 && waited < 20) begin cyc(); waited++; end
    n_checks++;
    if (waited != TICK_DIV) begin
      n_fail++; $display("FAIL %s_first_start: got %0d cycles required %0d", tag, waited, TICK_DIV);
    end
    ntog = 0;
    for (int j = 0; j < lat; j++) begin
      run_toggle = mask[j];
      if (mask[j]) ntog++;
      cyc();
    end
    run_toggle = 1'b0;
    exp_count = exp_count + 16'd1;
    if ((ntog % 2) == 1) begin
      bad = 1'b0;
      for (int c = 0; c < 2 * (TICK_DIV + lat); c++) begin
        if (gen_start !== 1'b0 || running !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        cyc();
      end
      n_checks++;
      if ({bad, gen_count} !== {1'b0, exp_count}) begin
        n_fail++; $display("FAIL %s_pause: got activity=%b cnt=%0d required 0 cnt=%0d",
                           tag, bad, gen_count, exp_count);
      end
    end else begin
      waited = 0;
      while (gen_start !== 1'b1 && waited < 20) begin cyc(); waited++; end
      n_checks++;
      if ({32'(waited), gen_count} !== {32'(TICK_DIV), exp_count}) begin
        n_fail++; $display("FAIL %s_continue: got gap=%0d cnt=%0d required gap=%0d cnt=%0d",
                           tag, waited, gen_count, TICK_DIV, exp_count);
      end
      for (int j = 0; j < lat; j++) cyc();
      exp_count = exp_count + 16'd1;
      pause_from_run(tag);
    end
  endtask

  task automatic test_load_in_wait();
    int   waited;
    logic bad;
    eng_lat = 3;
    run_toggle = 1'b1; cyc(); run_toggle = 1'b0;
    waited = 0;
    while (gen_start !== 1'b1 && waited < 20) begin cyc(); waited++; end
    load_req = 1'b1; sel_in = ~exp_sel;
    cyc();
    load_req = 1'b0;
    bad = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      if (cell_we !== 1'b0 || pat_sel !== exp_sel) bad = 1'b1;
      cyc();
    end
    exp_count = exp_count + 16'd1;
    n_checks++;
    if ({bad, running, gen_count} !== {1'b0, 1'b1, exp_count}) begin
      n_fail++; $display("FAIL load_in_wait: got bad=%b run=%b cnt=%0d required 0 1 %0d",
                         bad, running, gen_count, exp_count);
    end
    do_load(2'($urandom_range(0, 3)), 1'b0, "load_in_run");
  endtask

  task automatic test_load_toggle_same();
    logic bad;
    do_load(2'($urandom_range(0, 3)), 1'b1, "load_toggle");
    bad = 1'b0;
    for (int c = 0; c < 2 * TICK_DIV + 2; c++) begin
      if (running !== 1'b0 || gen_start !== 1'b0) bad = 1'b1;
      cyc();
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL load_toggle_lost: got activity=%b required 0", bad);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [26:0] got;
    logic        bad;
    sel_in = 2'($urandom_range(0, 3));
    load_req = 1'b1; cyc(); load_req = 1'b0;
    for (int j = 0; j < 4; j++) cyc();
    n_checks++;
    if ({cell_we, cell_addr} !== {1'b1, 4'd4}) begin
      n_fail++; $display("FAIL mid_load_pos: got we=%b addr=%0d required 1 4", cell_we, cell_addr);
    end
    reset_n = 1'b0; cyc(); reset_n = 1'b1;
    got = {pat_sel, cell_addr, cell_we, cell_wdata, gen_start, busy, running, gen_count};
    n_checks++;
    if (got !== 27'd0) begin
      n_fail++; $display("FAIL mid_load_reset: got %h required 0", got);
    end
    exp_count = 16'd0;
    run_toggle = 1'b1; cyc(); run_toggle = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (cell_we !== 1'b0 || busy !== 1'b0 || running !== 1'b0 || gen_start !== 1'b0) bad = 1'b1;
      cyc();
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got activity=%b required 0", bad);
    end
  endtask

  initial begin
    for (int p = 0; p < 4; p++) begin
      rom[p] = 16'($urandom);
      rom[p][15] = 1'b1;
    end
    rom[0][0] = 1'b1;

    test_reset();
    test_load();
    test_stepping();
    test_wait_toggle(3, 8'b0000_0010, "pause_in_wait");
    test_wait_toggle(3, 8'b0000_0011, "double_toggle");
    test_wait_toggle(3, 8'b0000_0100, "toggle_with_done");
    test_load_in_wait();
    test_load_toggle_same();
    test_reset_mid_load();
    do_load(2'($urandom_range(0, 3)), 1'b0, "reload");
    for (int r = 0; r < 4; r++) begin
      do_load(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rand_load");
      test_wait_toggle($urandom_range(1, 5), 8'($urandom), "rand_wait");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
